dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, max consecutive owned cycles before forced release (range 2..255).
REQ-002 SHALL have clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have req  input  3  access request per requester (bit0 CPU LD/ST, bit1 stack unit, bit2 debug/DMA port).
REQ-005 SHALL have lock  input  3  per requester: keep ownership after the current beat (multi-beat stack push/pop).
REQ-006 SHALL have wr  input  3  per requester: 1 = write, 0 = read.
REQ-007 SHALL have addr_in  input  24  packed {addr2,addr1,addr0}, 8 bits each.
REQ-008 SHALL have wdata_in  input  24  packed {wdata2,wdata1,wdata0}, 8 bits each.
REQ-009 SHALL have grant  output  3  one-hot, high in the cycle the owner's beat completes.
REQ-010 SHALL have rdata  output  8  shared read data, equal to mem_rdata.
REQ-011 SHALL have mem_addr, mem_wdata  output  8 each  memory address/write data, muxed from owner.
REQ-012 SHALL have mem_wr, mem_rd  output  1 each  memory strobes.
REQ-013 SHALL have mem_rdata  input  8; mem_rdy  input  1  memory completes the access this cycle.
REQ-014 SHALL have owner  output  2  current owner index, 3 = none; hold_err  output  1  sticky forced-release flag.

Function
REQ-015 SHALL implement FSM states IDLE and OWN; owner index and round-robin pointer are registered.
REQ-016 In IDLE with any req high, SHALL register the winner at the next edge and enter OWN; earliest grant is the following cycle (1-cycle arbitration latency).
REQ-017 Winner selection SHALL be round-robin starting at index (last_owner+1) mod 3; after reset last_owner=2, so CPU has first priority.
REQ-018 In OWN with req[owner]=1: mem_addr/mem_wdata from owner's slice, mem_wr=wr[owner], mem_rd=!wr[owner]; grant[owner]=mem_rdy.
REQ-019 In IDLE, or OWN with req[owner]=0: mem_wr=mem_rd=0, mem_addr=mem_wdata=0, grant=0.
REQ-020 On grant with lock[owner]=0, SHALL release; if another req is high, the next owner (round-robin, current owner lowest priority) is registered on the same edge, no idle cycle; else go IDLE.
REQ-021 On grant with lock[owner]=1, SHALL keep ownership for the next beat.
REQ-022 If req[owner] drops while in OWN, SHALL release at that edge per REQ-020 rules.
REQ-023 SHALL count owned cycles in an 8-bit hold counter, cleared on every ownership change; when it reaches MAX_HOLD-1 without release, SHALL force release at that edge, set hold_err, and pass to the next requester.
REQ-024 hold_err SHALL remain set until rst.
REQ-025 Non-owner grant bits SHALL always be 0; grant SHALL never have more than one bit set.
REQ-026 rdata SHALL be combinationally mem_rdata; requesters sample it when their grant is high.

Reset
REQ-027 On rst: state IDLE, owner=3, last_owner=2, hold counter 0, hold_err 0, grant 0, mem_wr=mem_rd=0, mem_addr=mem_wdata=0.
REQ-028 rst during OWN SHALL abort the access at that edge with no grant in the following cycle.

Structure
REQ-029 Requester index constants (REQ_CPU=0, REQ_STACK=1, REQ_DBG=2, OWNER_NONE=3) and state encodings SHALL live in the shared control definitions include.
REQ-030 SHALL contain one sub-module, rr_pick3: combinational 3-way round-robin picker (req, start index -> winner index, valid).

Verification
REQ-031 req=3'b001, wr0=1, addr0=8'h40, wdata0=8'hA5, mem_rdy=1 -> owner=0 next cycle, mem_wr=1 at 8'h40 with 8'hA5, grant=3'b001 for one cycle, then IDLE.
REQ-032 Stack push: req1=1, lock1=1 for 2 beats (addr 8'hFD then 8'hFC), CPU req0=1 throughout -> grant1 twice consecutively, CPU granted the cycle after lock drops.
REQ-033 All three req held high, unlocked, mem_rdy=1 -> grant order 0,1,2,0,1,2 with no idle cycle.
REQ-034 mem_rdy low 3 cycles in OWN -> outputs held stable, grant only in fourth cycle, read returns mem_rdata=8'h5C on rdata.
REQ-035 Owner 2 holds lock2=1, mem_rdy=0 -> forced release after MAX_HOLD=16 cycles, hold_err=1, pending req0 owns next cycle.
REQ-036 rst asserted mid stack pop -> owner=3, grant=0, hold_err=0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared control definitions for the data-memory arbiter: requester indices,
// FSM encoding and the modulo-3 index helper.
package dmem_arbiter_pkg;

  localparam logic [1:0] REQ_CPU    = 2'd0;
  localparam logic [1:0] REQ_STACK  = 2'd1;
  localparam logic [1:0] REQ_DBG    = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first set req bit at or after start,
// wrapping modulo 3.
module rr_pick3
  import dmem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = OWNER_NONE;
    idx    = start;
    for (int k = 0; k < 3; k++) begin
      if (winner == OWNER_NONE && req[idx]) winner = idx;
      idx = next_idx(idx);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU, stack unit and debug port share one 8-bit memory
// port with round-robin ownership, multi-beat lock and a hold-time watchdog.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  lock,
  input  logic [2:0]  wr,
  input  logic [23:0] addr_in,
  input  logic [23:0] wdata_in,
  output logic [2:0]  grant,
  output logic [7:0]  rdata,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdy,
  output logic [1:0]  owner,
  output logic        hold_err
);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic       err_q, err_d;

  logic [2:0] owner_mask;
  logic [2:0] pick_req;
  logic [1:0] pick_winner;
  logic       pick_valid;
  logic       own_active;
  logic       release_now;
  logic       forced;

  // A releasing owner is masked so it cannot immediately win again.
  always_comb begin
    owner_mask = 3'b000;
    if (state_q == ST_OWN) begin
      case (owner_q)
        REQ_CPU:   owner_mask = 3'b001;
        REQ_STACK: owner_mask = 3'b010;
        REQ_DBG:   owner_mask = 3'b100;
        default:   owner_mask = 3'b000;
      endcase
    end
  end

  assign pick_req = req & ~owner_mask;

  rr_pick3 u_pick (
    .req    (pick_req),
    .start  (next_idx(last_q)),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign own_active = (state_q == ST_OWN) && |(req & owner_mask);

  always_comb begin
    grant     = 3'b000;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    if (own_active) begin
      grant  = mem_rdy ? owner_mask : 3'b000;
      mem_wr = |(wr & owner_mask);
      mem_rd = ~|(wr & owner_mask);
      case (owner_q)
        REQ_CPU: begin
          mem_addr  = addr_in[7:0];
          mem_wdata = wdata_in[7:0];
        end
        REQ_STACK: begin
          mem_addr  = addr_in[15:8];
          mem_wdata = wdata_in[15:8];
        end
        default: begin
          mem_addr  = addr_in[23:16];
          mem_wdata = wdata_in[23:16];
        end
      endcase
    end
  end

  assign release_now = !own_active || (mem_rdy && !(|(lock & owner_mask)));
  assign forced      = !release_now && (hold_q == 8'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWN;
          owner_d = pick_winner;
          last_d  = pick_winner;
          hold_d  = 8'd0;
        end
      end
      default: begin
        if (release_now || forced) begin
          if (forced) err_d = 1'b1;
          hold_d = 8'd0;
          if (pick_valid) begin
            owner_d = pick_winner;
            last_d  = pick_winner;
          end else begin
            state_d = ST_IDLE;
            owner_d = OWNER_NONE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      last_q  <= REQ_DBG;
      hold_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign rdata    = mem_rdata;
  assign owner    = owner_q;
  assign hold_err = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: inputs change and outputs are
// sampled just after the falling edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, lock, wr;
  logic [7:0]  a [3];
  logic [7:0]  wd [3];
  logic [23:0] addr_in, wdata_in;
  logic [2:0]  grant;
  logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_rd, mem_rdy, hold_err;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;

  assign addr_in  = {a[2], a[1], a[0]};
  assign wdata_in = {wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .wr        (wr),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .grant     (grant),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .owner     (owner),
    .hold_err  (hold_err)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; lock = 3'b000; wr = 3'b000;
    a[0] = 8'h00; a[1] = 8'h00; a[2] = 8'h00;
    wd[0] = 8'h00; wd[1] = 8'h00; wd[2] = 8'h00;
    mem_rdy = 1'b0; mem_rdata = 8'h00;
    step(); step();
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL reset_owner got=%0d want=3", owner); end
    n_checks++;
    if ({grant, mem_wr, mem_rd, hold_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b want=000000", {grant, mem_wr, mem_rd, hold_err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_bus got=%h want=0000", {mem_addr, mem_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    step();
    req = 3'b001; wr = 3'b001; a[0] = 8'h40; wd[0] = 8'hA5; mem_rdy = 1'b1;
    #1;
    n_checks++;
    if ({owner, grant} !== {2'd3, 3'b000}) begin
      n_fail++; $display("FAIL sw_arb_latency owner=%0d grant=%b want owner=3 grant=000", owner, grant);
    end
    step();
    n_checks++;
    if ({owner, grant, mem_wr, mem_rd} !== {2'd0, 3'b001, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw_grant owner=%0d grant=%b wr=%b rd=%b want 0/001/1/0", owner, grant, mem_wr, mem_rd);
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 16'h40A5) begin
      n_fail++; $display("FAIL sw_bus got=%h want=40a5", {mem_addr, mem_wdata});
    end
    step();
    req = 3'b000; wr = 3'b000;
    #1;
    n_checks++;
    if ({owner, grant, mem_wr} !== {2'd3, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL sw_idle owner=%0d grant=%b wr=%b want 3/000/0", owner, grant, mem_wr);
    end
  endtask

  task automatic test_stack_push();
    step();
    req = 3'b010; lock = 3'b010; wr = 3'b010; a[1] = 8'hFD; wd[1] = 8'h11; mem_rdy = 1'b1;
    step();
    n_checks++;
    if ({owner, grant, mem_addr} !== {2'd1, 3'b010, 8'hFD}) begin
      n_fail++; $display("FAIL push_beat1 owner=%0d grant=%b addr=%h want 1/010/fd", owner, grant, mem_addr);
    end
    req = 3'b011; a[0] = 8'h20;
    step();
    a[1] = 8'hFC; lock = 3'b000;
    #1;
    n_checks++;
    if ({owner, grant, mem_addr, mem_wr} !== {2'd1, 3'b010, 8'hFC, 1'b1}) begin
      n_fail++; $display("FAIL push_beat2 owner=%0d grant=%b addr=%h wr=%b want 1/010/fc/1", owner, grant, mem_addr, mem_wr);
    end
    step();
    req = 3'b001; wr = 3'b000;
    #1;
    n_checks++;
    if ({owner, grant, mem_rd, mem_addr} !== {2'd0, 3'b001, 1'b1, 8'h20}) begin
      n_fail++; $display("FAIL push_cpu_next owner=%0d grant=%b rd=%b addr=%h want 0/001/1/20", owner, grant, mem_rd, mem_addr);
    end
    step();
    req = 3'b000;
    #1;
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL push_idle owner=%0d want=3", owner); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0; req = 3'b111; lock = 3'b000; wr = 3'b000; mem_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g = 3'b001 << (k % 3);
      n_checks++;
      if (grant !== exp_g) begin
        n_fail++; $display("FAIL rr_order beat=%0d grant=%b want=%b", k, grant, exp_g);
      end
    end
    step();
    req = 3'b000;
    step();
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL rr_idle owner=%0d want=3", owner); end
  endtask

  task automatic test_wait_states();
    req = 3'b100; wr = 3'b000; a[2] = 8'h77; mem_rdy = 1'b0; mem_rdata = 8'h5C;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({owner, grant, mem_rd, mem_addr} !== {2'd2, 3'b000, 1'b1, 8'h77}) begin
        n_fail++; $display("FAIL ws_hold cyc=%0d owner=%0d grant=%b rd=%b addr=%h want 2/000/1/77", k, owner, grant, mem_rd, mem_addr);
      end
    end
    step();
    mem_rdy = 1'b1;
    #1;
    n_checks++;
    if ({grant, rdata} !== {3'b100, 8'h5C}) begin
      n_fail++; $display("FAIL ws_read grant=%b rdata=%h want 100/5c", grant, rdata);
    end
    step();
    req = 3'b000;
    #1;
    n_checks++;
    if (owner !== 2'd3) begin n_fail++; $display("FAIL ws_idle owner=%0d want=3", owner); end
  endtask

  task automatic test_hold_timeout();
    req = 3'b100; lock = 3'b100; wr = 3'b000; mem_rdy = 1'b0;
    step();
    req = 3'b101;
    for (int k = 1; k <= 16; k++) begin
      n_checks++;
      if ({owner, hold_err} !== {2'd2, 1'b0}) begin
        n_fail++; $display("FAIL to_owned cyc=%0d owner=%0d err=%b want 2/0", k, owner, hold_err);
      end
      step();
    end
    n_checks++;
    if ({owner, hold_err, grant} !== {2'd0, 1'b1, 3'b000}) begin
      n_fail++; $display("FAIL to_forced owner=%0d err=%b grant=%b want 0/1/000", owner, hold_err, grant);
    end
    mem_rdy = 1'b1;
    #1;
    n_checks++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL to_cpu_grant grant=%b want=001", grant); end
    step();
    req = 3'b000; lock = 3'b000;
    step();
    n_checks++;
    if ({owner, hold_err} !== {2'd3, 1'b1}) begin
      n_fail++; $display("FAIL to_sticky owner=%0d err=%b want 3/1", owner, hold_err);
    end
  endtask

  task automatic test_reset_mid_pop();
    req = 3'b010; lock = 3'b010; wr = 3'b000; a[1] = 8'hFC; mem_rdy = 1'b1;
    step();
    n_checks++;
    if ({owner, grant} !== {2'd1, 3'b010}) begin
      n_fail++; $display("FAIL pop_beat owner=%0d grant=%b want 1/010", owner, grant);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({owner, grant, hold_err, mem_rd} !== {2'd3, 3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL pop_reset owner=%0d grant=%b err=%b rd=%b want 3/000/0/0", owner, grant, hold_err, mem_rd);
    end
    rst = 1'b0; req = 3'b000; lock = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_stack_push();
    test_back_to_back();
    test_wait_states();
    test_hold_timeout();
    test_reset_mid_pop();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
